vga_pattern_gen: RTL and testbench



---
 rtl/vga_pkg.sv | 59 +++++
 rtl/vga_timing.sv | 77 +++++++
 rtl/vga_pattern_gen.sv | 159 +++++++++++++++
 tb/tb_vga_pattern_gen.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
//------------------------------------------------------------------------------
// Module      : vga_pkg
// Description : Shared encodings for the VGA pattern generator: mode codes,
//               colour-bar channel enables and a full-scale colour builder.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package vga_pkg;

    localparam int NUM_MODES = 6;

    localparam logic [2:0] MODE_BARS  = 3'd0;
    localparam logic [2:0] MODE_CHECK = 3'd1;
    localparam logic [2:0] MODE_RAMP  = 3'd2;
    localparam logic [2:0] MODE_RED   = 3'd3;
    localparam logic [2:0] MODE_GREEN = 3'd4;
    localparam logic [2:0] MODE_BLUE  = 3'd5;

    // {R,G,B} channel enables of the eight bars, left to right
    localparam logic [2:0] BAR_WHITE   = 3'b111;
    localparam logic [2:0] BAR_YELLOW  = 3'b110;
    localparam logic [2:0] BAR_CYAN    = 3'b011;
    localparam logic [2:0] BAR_GREEN   = 3'b010;
    localparam logic [2:0] BAR_MAGENTA = 3'b101;
    localparam logic [2:0] BAR_RED     = 3'b100;
    localparam logic [2:0] BAR_BLUE    = 3'b001;
    localparam logic [2:0] BAR_BLACK   = 3'b000;

    function automatic logic [2:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return BAR_WHITE;
            3'd1:    return BAR_YELLOW;
            3'd2:    return BAR_CYAN;
            3'd3:    return BAR_GREEN;
            3'd4:    return BAR_MAGENTA;
            3'd5:    return BAR_RED;
            3'd6:    return BAR_BLUE;
            default: return BAR_BLACK;
        endcase
    endfunction

    // Packs {R,G,B} with each enabled channel at all ones; caller truncates.
    function automatic logic [47:0] full_scale(input logic [2:0] en,
                                               input int r_w,
                                               input int g_w,
                                               input int b_w);
        logic [47:0] r;
        logic [47:0] g;
        logic [47:0] b;
        r = en[2] ? ((48'd1 << r_w) - 48'd1) : 48'd0;
        g = en[1] ? ((48'd1 << g_w) - 48'd1) : 48'd0;
        b = en[0] ? ((48'd1 << b_w) - 48'd1) : 48'd0;
        return (r << (g_w + b_w)) | (g << b_w) | b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_timing.sv
//------------------------------------------------------------------------------
// Module      : vga_timing
// Description : Raster counters, registered hsync/vsync/de and frame-end strobe.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vga_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW      = $clog2(H_TOTAL),
    localparam int VW      = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          active,
    output logic          frame_end,
    output logic          hsync,
    output logic          vsync,
    output logic          de
);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic w_h_last;
    logic w_v_last;
    logic w_hs_on;
    logic w_vs_on;

    assign w_h_last  = (h_cnt == H_LAST);
    assign w_v_last  = (v_cnt == V_LAST);
    assign frame_end = w_h_last && w_v_last;
    assign active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign w_hs_on   = (h_cnt >= HS_START) && (h_cnt < HS_END);
    assign w_vs_on   = (v_cnt >= VS_START) && (v_cnt < VS_END);

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
            hsync <= ~SYNC_POL;
            vsync <= ~SYNC_POL;
            de    <= 1'b0;
        end else begin
            hsync <= w_hs_on ? SYNC_POL : ~SYNC_POL;
            vsync <= w_vs_on ? SYNC_POL : ~SYNC_POL;
            de    <= active;
            if (w_h_last) begin
                h_cnt <= '0;
                v_cnt <= w_v_last ? '0 : v_cnt + VW'(1);
            end else begin
                h_cnt <= h_cnt + HW'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/vga_pattern_gen.sv
//------------------------------------------------------------------------------
// Module      : vga_pattern_gen
// Description : Parametrised VGA timing and six-pattern test generator with
//               tear-free mode stepping. Optional macro VGA_BORDER_EN forces a
//               white one-pixel border around the active area.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit SYNC_POL   = 1'b0,
    parameter int R_W        = 5,
    parameter int G_W        = 6,
    parameter int B_W        = 5,
    parameter int CHECK_LOG2 = 5,
    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW        = $clog2(H_TOTAL),
    localparam int VW        = $clog2(V_TOTAL),
    localparam int RGB_W     = R_W + G_W + B_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_flag,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [RGB_W-1:0] rgb,
    output logic [HW-1:0]    pix_x,
    output logic [VW-1:0]    pix_y,
    output logic             frame_start,
    output logic [2:0]       mode
);

    localparam int               XA     = $clog2(H_ACTIVE);
    localparam logic [HW-1:0]    BAR_W  = HW'(H_ACTIVE / 8);
    localparam logic [RGB_W-1:0] WHITE  = RGB_W'(full_scale(3'b111, R_W, G_W, B_W));
    localparam logic [RGB_W-1:0] RED    = RGB_W'(full_scale(3'b100, R_W, G_W, B_W));
    localparam logic [RGB_W-1:0] GREEN  = RGB_W'(full_scale(3'b010, R_W, G_W, B_W));
    localparam logic [RGB_W-1:0] BLUE   = RGB_W'(full_scale(3'b001, R_W, G_W, B_W));

    logic [HW-1:0]    h_cnt;
    logic [VW-1:0]    v_cnt;
    logic             w_active;
    logic             w_frame_end;
    logic [2:0]       r_pend_mode;
    logic [2:0]       r_cur_mode;
    logic [2:0]       w_pend_next;
    logic [HW-1:0]    w_bar_idx;
    logic [RGB_W-1:0] w_pattern;
    logic [RGB_W-1:0] w_pixel;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .SYNC_POL (SYNC_POL)
    ) u_timing (
        .clk       (clk),
        .rst       (rst),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .active    (w_active),
        .frame_end (w_frame_end),
        .hsync     (hsync),
        .vsync     (vsync),
        .de        (de)
    );

    always_comb begin
        w_pend_next = r_pend_mode;
        if (key_flag) begin
            w_pend_next = (r_pend_mode == 3'(NUM_MODES - 1)) ? 3'd0 : r_pend_mode + 3'd1;
        end
    end

    // Pattern swaps only at the last raster position, so a frame never tears
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_mode <= 3'd0;
            r_cur_mode  <= 3'd0;
        end else begin
            r_pend_mode <= w_pend_next;
            if (w_frame_end) begin
                r_cur_mode <= w_pend_next;
            end
        end
    end

    assign w_bar_idx = h_cnt / BAR_W;

    always_comb begin
        w_pattern = '0;
        case (r_cur_mode)
            MODE_BARS: begin
                if (w_bar_idx < HW'(8)) begin
                    w_pattern = RGB_W'(full_scale(bar_colour(w_bar_idx[2:0]), R_W, G_W, B_W));
                end
            end
            MODE_CHECK: begin
                if (h_cnt[CHECK_LOG2] ^ v_cnt[CHECK_LOG2]) begin
                    w_pattern = WHITE;
                end
            end
            MODE_RAMP: begin
                w_pattern = {R_W'(h_cnt >> (XA - R_W)),
                             G_W'(h_cnt >> (XA - G_W)),
                             B_W'(h_cnt >> (XA - B_W))};
            end
            MODE_RED:   w_pattern = RED;
            MODE_GREEN: w_pattern = GREEN;
            MODE_BLUE:  w_pattern = BLUE;
            default:    w_pattern = '0;
        endcase
    end

`ifdef VGA_BORDER_EN
    logic w_border;
    assign w_border = (h_cnt == '0) || (h_cnt == HW'(H_ACTIVE - 1)) ||
                      (v_cnt == '0) || (v_cnt == VW'(V_ACTIVE - 1));
    assign w_pixel  = w_border ? WHITE : w_pattern;
`else
    assign w_pixel  = w_pattern;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb         <= '0;
            pix_x       <= '0;
            pix_y       <= '0;
            frame_start <= 1'b0;
            mode        <= 3'd0;
        end else begin
            rgb         <= w_active ? w_pixel : '0;
            pix_x       <= h_cnt;
            pix_y       <= v_cnt;
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
            mode        <= r_cur_mode;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vga_pattern_gen.sv
//------------------------------------------------------------------------------
// Module      : tb_vga_pattern_gen
// Description : Self-checking bench for vga_pattern_gen on a shrunken raster
//               (68x16 active, 84x24 total) with directed vectors.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_vga_pattern_gen;

    localparam int H_ACTIVE = 68;
    localparam int H_FP     = 4;
    localparam int H_SYNC   = 8;
    localparam int H_BP     = 4;
    localparam int V_ACTIVE = 16;
    localparam int V_FP     = 2;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 4;
    localparam int H_TOTAL  = 84;
    localparam int V_TOTAL  = 24;
    localparam int FRAME    = H_TOTAL * V_TOTAL;
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);

    typedef struct {
        logic [2:0]  m;
        int          x;
        int          y;
        logic [15:0] exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          key_flag = 1'b0;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic [15:0]   rgb;
    logic [HW-1:0] pix_x;
    logic [VW-1:0] pix_y;
    logic          frame_start;
    logic [2:0]    mode;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [2:0] cur = 3'd0;
    vec_t       tbl[$];
    int hs_low, hs_line0, hs_first, vs_low, vs_first, de_high, fs_cnt, fs2_t, bad_blank, early;

    always #5 clk = ~clk;

    vga_pattern_gen #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .SYNC_POL (1'b0), .R_W (5), .G_W (6), .B_W (5), .CHECK_LOG2 (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_flag    (key_flag),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .rgb         (rgb),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .frame_start (frame_start),
        .mode        (mode)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, " hsync"}, 32'(hsync), 32'd1);
        check({tag, " vsync"}, 32'(vsync), 32'd1);
        check({tag, " de"}, 32'(de), 32'd0);
        check({tag, " rgb"}, 32'(rgb), 32'd0);
        check({tag, " pix_x"}, 32'(pix_x), 32'd0);
        check({tag, " pix_y"}, 32'(pix_y), 32'd0);
        check({tag, " frame_start"}, 32'(frame_start), 32'd0);
        check({tag, " mode"}, 32'(mode), 32'd0);
    endtask

    task automatic wait_pos(input int x, input int y);
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (int'(pix_x) == x && int'(pix_y) == y) return;
        end
        n_cmp++;
        n_err++;
        $display("FAIL wait_pos(%0d,%0d): not reached within %0d cycles", x, y, 2 * FRAME);
    endtask

    task automatic wait_fs();
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (frame_start) return;
        end
        n_cmp++;
        n_err++;
        $display("FAIL wait_fs: no frame_start within %0d cycles", 2 * FRAME);
    endtask

    task automatic press();
        key_flag = 1'b1;
        @(negedge clk);
        key_flag = 1'b0;
    endtask

    task automatic set_mode(input logic [2:0] m);
        int k;
        k = (int'(m) - int'(cur) + 6) % 6;
        wait_pos(0, 2);
        for (int i = 0; i < k; i++) press();
        wait_fs();
        check($sformatf("mode switch to %0d", m), 32'(mode), 32'(m));
        cur = m;
    endtask

    task automatic add(input logic [2:0] m, input int x, input int y, input logic [15:0] exp);
        vec_t v;
        v.m = m; v.x = x; v.y = y; v.exp = exp;
        tbl.push_back(v);
    endtask

    initial begin
        add(3'd1, 8, 1, 16'hFFFF);  add(3'd1, 16, 1, 16'h0000);
        add(3'd1, 1, 1, 16'h0000);  add(3'd1, 8, 9, 16'h0000);
        add(3'd1, 20, 9, 16'hFFFF);
        add(3'd2, 3, 4, 16'h0020);  add(3'd2, 20, 4, 16'h2945);
        add(3'd2, 65, 4, 16'h8410); add(3'd2, 66, 4, 16'h8430);
        add(3'd3, 10, 5, 16'hF800);
        add(3'd4, 10, 5, 16'h07E0);
`ifdef VGA_BORDER_EN
        add(3'd5, 10, 0, 16'hFFFF); add(3'd5, 1, 1, 16'h001F);
        add(3'd5, 0, 5, 16'hFFFF);  add(3'd5, 67, 5, 16'hFFFF);
        add(3'd5, 10, 15, 16'hFFFF);
`else
        add(3'd5, 10, 0, 16'h001F); add(3'd5, 1, 1, 16'h001F);
        add(3'd5, 0, 5, 16'h001F);  add(3'd5, 67, 5, 16'h001F);
        add(3'd5, 10, 15, 16'h001F);
`endif
        add(3'd0, 1, 3, 16'hFFFF);  add(3'd0, 8, 3, 16'hFFE0);
        add(3'd0, 15, 3, 16'hFFE0); add(3'd0, 16, 3, 16'h07FF);
        add(3'd0, 24, 3, 16'h07E0); add(3'd0, 32, 3, 16'hF81F);
        add(3'd0, 40, 3, 16'hF800); add(3'd0, 48, 3, 16'h001F);
        add(3'd0, 56, 3, 16'h0000); add(3'd0, 64, 3, 16'h0000);

        // Reset state, then one full frame of timing measurements
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        @(negedge clk);
        check("first frame_start", 32'(frame_start), 32'd1);
        check("first pixel rgb", 32'(rgb), 32'hFFFF);
        hs_low = 0; hs_line0 = 0; hs_first = -1; vs_low = 0; vs_first = -1;
        de_high = 0; fs_cnt = 0; fs2_t = -1; bad_blank = 0;
        for (int t = 0; t <= FRAME; t++) begin
            if (t > 0) @(negedge clk);
            if (frame_start) begin
                fs_cnt++;
                if (t > 0 && fs2_t < 0) fs2_t = t;
            end
            if (t < FRAME) begin
                if (!hsync) begin
                    hs_low++;
                    if (t < H_TOTAL) hs_line0++;
                    if (hs_first < 0) hs_first = t;
                end
                if (!vsync) begin
                    vs_low++;
                    if (vs_first < 0) vs_first = t;
                end
                if (de) de_high++;
                if (!de && rgb != 16'h0000) bad_blank++;
            end
        end
        check("hsync first low offset", 32'(hs_first), 32'd72);
        check("hsync low per line", 32'(hs_line0), 32'd8);
        check("hsync low per frame", 32'(hs_low), 32'd192);
        check("vsync first low offset", 32'(vs_first), 32'd1512);
        check("vsync low per frame", 32'(vs_low), 32'd168);
        check("de high per frame", 32'(de_high), 32'd1088);
        check("frame period", 32'(fs2_t), 32'(FRAME));
        check("frame_start pulses", 32'(fs_cnt), 32'd2);
        check("rgb nonzero in blanking", 32'(bad_blank), 32'd0);

        // Mid-frame key: mode must hold until the frame wraps
        wait_pos(0, 10);
        press();
        early = 0;
        for (int i = 0; i < 2 * FRAME && !frame_start; i++) begin
            @(negedge clk);
            if (!frame_start && mode != 3'd0) early++;
        end
        check("mode held mid-frame", 32'(early), 32'd0);
        check("mode at frame_start", 32'(mode), 32'd1);
        check("frame_start after key", 32'(frame_start), 32'd1);
        cur = 3'd1;

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].m != cur) set_mode(tbl[i].m);
            wait_pos(tbl[i].x, tbl[i].y);
            check($sformatf("m%0d rgb(%0d,%0d)", tbl[i].m, tbl[i].x, tbl[i].y),
                  32'(rgb), 32'(tbl[i].exp));
        end

        // Seven presses in one frame accumulate to 7 mod 6
        wait_pos(0, 2);
        repeat (7) press();
        wait_fs();
        check("mode after 7 keys", 32'(mode), 32'd1);

        // Key on the exact frame-end cycle is loaded
        wait_pos(H_TOTAL - 2, V_TOTAL - 1);
        press();
        wait_fs();
        check("mode after frame-end key", 32'(mode), 32'd2);

        // Mid-frame reset with keys during reset
        wait_pos(30, 10);
        rst = 1'b1;
        key_flag = 1'b1;
        @(negedge clk);
        key_flag = 1'b0;
        check_reset("midframe rst");
        @(negedge clk);
        key_flag = 1'b1;
        @(negedge clk);
        key_flag = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("frame_start after rst", 32'(frame_start), 32'd1);
        check("pix_x after rst", 32'(pix_x), 32'd0);
        check("mode after rst", 32'(mode), 32'd0);
        wait_fs();
        check("key during rst ignored", 32'(mode), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
